// File: rtl/uart_baud_gen.sv
// Fractional-N UART baud generator.
// Two prescaler chains (TX free-running, RX re-phasable) share one active
// divisor. Each chain divides clk by act_int, stretched by one cycle whenever
// its fractional accumulator overflows, giving an average oversample period of
// act_int + act_frac/2^FRAC_W. A pending divisor is swapped in on a TX bit
// boundary so that no bit ever mixes two divisors.
module uart_baud_gen #(
  parameter int CNT_W        = 12,
  parameter int FRAC_W       = 4,
  parameter int OVERSAMPLE   = 16,
  parameter int DEFAULT_INT  = 32,
  parameter int DEFAULT_FRAC = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CNT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  output logic              div_ack,
  input  logic              rx_restart,
  output logic              tx_os_tick,
  output logic              tx_tick,
  output logic              bd_clk,
  output logic              rx_os_tick,
  output logic              rx_sample
);

  // Prescalers are one bit wider than the divisor: act_int plus a carry can
  // reach 2^CNT_W.
  localparam int PW   = CNT_W + 1;
  localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OS_W-1:0]   OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]   OS_HALF  = OS_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0]  RST_INT  = (DEFAULT_INT < 2) ? CNT_W'(2) : CNT_W'(DEFAULT_INT);
  localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(DEFAULT_FRAC);

  logic [CNT_W-1:0]  act_int_reg;
  logic [FRAC_W-1:0] act_frac_reg;
  logic [CNT_W-1:0]  pend_int_reg;
  logic [FRAC_W-1:0] pend_frac_reg;
  logic              pend_valid_reg;

  logic              div_ack_reg;
  logic              tx_os_tick_reg;
  logic              tx_tick_reg;
  logic              bd_clk_reg;
  logic              rx_os_tick_reg;
  logic              rx_sample_reg;

  // Per-chain status; index 0 is TX, index 1 is RX.
  logic [1:0]        restart;
  logic [1:0]        fire;
  logic [1:0]        wrap;
  logic              tx_high_next;
  logic              rx_mid;
  logic              apply;
  logic [CNT_W-1:0]  load_int;
  logic [CNT_W-1:0]  div_int_clamped;

  // TX is never re-phased; only the RX chain sees a restart.
  assign restart = {rx_restart, 1'b0};

  // A pending divisor goes live on the edge that ends a TX bit, or at once
  // while counting is frozen (no bit is in flight to be corrupted).
  assign apply = pend_valid_reg && (!en || wrap[0]);

  // Any period that starts on the apply edge already uses the new divisor.
  assign load_int = apply ? pend_int_reg : act_int_reg;

  // Divide-by-0/1 cannot produce one-cycle ticks from a reload counter.
  assign div_int_clamped = (div_int < CNT_W'(2)) ? CNT_W'(2) : div_int;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chain
      logic [PW-1:0]     cnt_reg;
      logic [PW-1:0]     cnt_next;
      logic [FRAC_W-1:0] acc_reg;
      logic [FRAC_W-1:0] acc_next;
      logic [OS_W-1:0]   os_reg;
      logic [OS_W-1:0]   os_next;
      logic [FRAC_W:0]   sum;

      // Period completes when the down-counter sits at 1; restart pre-empts it.
      assign fire[gi] = en && !restart[gi] && (cnt_reg == PW'(1));
      assign wrap[gi] = fire[gi] && (os_reg == OS_LAST);
      assign sum      = {1'b0, acc_reg} + {1'b0, act_frac_reg};

      if (gi == 0) begin : g_tx
        assign tx_high_next = (os_next >= OS_HALF);
      end else begin : g_rx
        assign rx_mid = fire[gi] && (os_reg == OS_HALF - OS_W'(1));
      end

      // Next prescaler / accumulator / phase for this chain.
      always_comb begin
        cnt_next = cnt_reg;
        acc_next = acc_reg;
        os_next  = os_reg;
        if (restart[gi]) begin
          cnt_next = {1'b0, load_int};
          acc_next = '0;
          os_next  = '0;
        end else if (fire[gi]) begin
          os_next = wrap[gi] ? '0 : os_reg + OS_W'(1);
          if (apply) begin
            cnt_next = {1'b0, load_int};
            acc_next = '0;
          end else begin
            cnt_next = {1'b0, act_int_reg} + PW'(sum[FRAC_W]);
            acc_next = sum[FRAC_W-1:0];
          end
        end else begin
          if (en) begin
            cnt_next = cnt_reg - PW'(1);
          end
          if (apply) begin
            acc_next = '0;
          end
        end
      end

      // Chain state register.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= {1'b0, RST_INT};
          acc_reg <= '0;
          os_reg  <= '0;
        end else begin
          cnt_reg <= cnt_next;
          acc_reg <= acc_next;
          os_reg  <= os_next;
        end
      end
    end
  endgenerate

  // Active / pending divisor: apply consumes pending, a new load refills it.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_int_reg    <= RST_INT;
      act_frac_reg   <= RST_FRAC;
      pend_int_reg   <= RST_INT;
      pend_frac_reg  <= RST_FRAC;
      pend_valid_reg <= 1'b0;
    end else begin
      if (apply) begin
        act_int_reg    <= pend_int_reg;
        act_frac_reg   <= pend_frac_reg;
        pend_valid_reg <= 1'b0;
      end
      if (div_load) begin
        pend_int_reg   <= div_int_clamped;
        pend_frac_reg  <= div_frac;
        pend_valid_reg <= 1'b1;
      end
    end
  end

  // Registered strobes and baud square wave.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_ack_reg    <= 1'b0;
      tx_os_tick_reg <= 1'b0;
      tx_tick_reg    <= 1'b0;
      bd_clk_reg     <= 1'b0;
      rx_os_tick_reg <= 1'b0;
      rx_sample_reg  <= 1'b0;
    end else begin
      div_ack_reg    <= apply;
      tx_os_tick_reg <= fire[0];
      tx_tick_reg    <= wrap[0];
      bd_clk_reg     <= tx_high_next;
      rx_os_tick_reg <= fire[1];
      rx_sample_reg  <= rx_mid;
    end
  end

  assign div_ack    = div_ack_reg;
  assign tx_os_tick = tx_os_tick_reg;
  assign tx_tick    = tx_tick_reg;
  assign bd_clk     = bd_clk_reg;
  assign rx_os_tick = rx_os_tick_reg;
  assign rx_sample  = rx_sample_reg;

endmodule
